// File: rtl/frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_if
// Description : Bundle of the write (SPI controller) and read (panel scanner)
//               signals of the double-buffered frame store.
//               master : the side that drives writes, reads and frame events
//               slave  : the frame buffer itself
//               Write side : wen, wrow, wcol, wdata, loaded -> ready
//               Read side  : ren, rrow, rcol, frame_end -> rdata, rvalid
//               Status     : swapped (one-cycle pulse on bank exchange)
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_buffer_if #(
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8
);
  localparam int RW = (rows    > 1) ? $clog2(rows)    : 1;
  localparam int CW = (columns > 1) ? $clog2(columns) : 1;
  localparam int PW = 3 * bitwidth;

  logic          wen;
  logic [RW-1:0] wrow;
  logic [CW-1:0] wcol;
  logic [PW-1:0] wdata;
  logic          loaded;
  logic          ready;
  logic          frame_end;
  logic          ren;
  logic [RW-1:0] rrow;
  logic [CW-1:0] rcol;
  logic [PW-1:0] rdata;
  logic          rvalid;
  logic          swapped;

  modport master (
    output wen, wrow, wcol, wdata, loaded, frame_end, ren, rrow, rcol,
    input  ready, rdata, rvalid, swapped
  );

  modport slave (
    input  wen, wrow, wcol, wdata, loaded, frame_end, ren, rrow, rcol,
    output ready, rdata, rvalid, swapped
  );
endinterface
`default_nettype wire

// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer
// Description : Double-buffered pixel store. The writer fills the back bank
//               while the scanner reads the front bank; after the writer
//               signals a complete frame, the banks exchange at the scanner's
//               next end-of-frame.
//               clk : single clock, rising edge
//               rst : asynchronous, active-low reset
//               bus : frame_buffer_if.slave (write port, read port, status)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer #(
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  frame_buffer_if.slave bus
);
  localparam int DEPTH = rows * columns;
  localparam int AW    = $clog2(2 * DEPTH);
  localparam int PW    = 3 * bitwidth;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_fsel;
  logic          r_ready;
  logic          r_swapped;
  logic          r_rvalid;
  logic [PW-1:0] r_rdata;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;

  // Both banks share one array; bank b occupies [b*DEPTH, (b+1)*DEPTH).
  // Deliberately not reset so it can map onto block RAM.
  logic [PW-1:0] r_mem [0:2*DEPTH-1];

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_FILL;
      r_fsel    <= 1'b0;
      r_ready   <= 1'b1;
      r_swapped <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      // Derived from the next state so both are registered and line up
      // with the state they describe.
      r_ready   <= (w_next_state == ST_FILL);
      r_swapped <= (w_next_state == ST_SWAP);
      if (r_state == ST_SWAP) begin
        r_fsel <= ~r_fsel;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FILL:    if (bus.loaded)    w_next_state = ST_PENDING;
      ST_PENDING: if (bus.frame_end) w_next_state = ST_SWAP;
      ST_SWAP:                       w_next_state = ST_FILL;
      default:                       w_next_state = ST_FILL;
    endcase
  end

  // ------------------------------------------------------------ write port
  // Writes are only accepted while filling (including the loaded cycle);
  // anything else is dropped without notice.
  assign w_we    = bus.wen && (r_state == ST_FILL);
  assign w_waddr = AW'((r_fsel ? 0 : DEPTH)
                     + int'(bus.wrow) * columns + int'(bus.wcol));

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= bus.wdata;
    end
  end

  // ------------------------------------------------------------- read port
  // Uses the current fsel, so a read issued during SWAP still sees the old
  // front bank; the toggle takes effect for reads from the next cycle on.
  assign w_raddr = AW'((r_fsel ? DEPTH : 0)
                     + int'(bus.rrow) * columns + int'(bus.rcol));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= bus.ren;
      if (bus.ren) begin
        r_rdata <= r_mem[w_raddr];
      end
    end
  end

  assign bus.ready   = r_ready;
  assign bus.swapped = r_swapped;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer
// Description : Directed self-checking bench for frame_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer;
  localparam int ROWS = 8;
  localparam int COLS = 32;
  localparam int BW   = 8;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  frame_buffer_if #(.rows(ROWS), .columns(COLS), .bitwidth(BW)) bus ();

  frame_buffer #(.rows(ROWS), .columns(COLS), .bitwidth(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] px(input int r, input logic [7:0] tag, input int c);
    return {8'(r), tag, 8'(c)};
  endfunction

  task automatic fill_frame(input logic [7:0] tag);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.wen   = 1'b1;
        bus.wrow  = RW'(r);
        bus.wcol  = CW'(c);
        bus.wdata = px(r, tag, c);
        tick();
      end
    end
    bus.wen = 1'b0;
  endtask

  task automatic write_px(input int r, input int c, input logic [23:0] d);
    bus.wen   = 1'b1;
    bus.wrow  = RW'(r);
    bus.wcol  = CW'(c);
    bus.wdata = d;
    tick();
    bus.wen   = 1'b0;
  endtask

  task automatic read_px(input string tag, input int r, input int c, input logic [23:0] exp);
    bus.ren  = 1'b1;
    bus.rrow = RW'(r);
    bus.rcol = CW'(c);
    tick();
    bus.ren  = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check({tag, "_rdata"},  32'(bus.rdata),  32'(exp));
  endtask

  task automatic pulse_loaded();
    bus.loaded = 1'b1;
    tick();
    bus.loaded = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.wen       = 1'b0;
    bus.wrow      = '0;
    bus.wcol      = '0;
    bus.wdata     = '0;
    bus.loaded    = 1'b0;
    bus.frame_end = 1'b0;
    bus.ren       = 1'b0;
    bus.rrow      = '0;
    bus.rcol      = '0;

    // ---- reset state
    tick(); tick();
    check("rst_ready",   32'(bus.ready),   32'd1);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rdata",   32'(bus.rdata),   32'd0);
    check("rst_swapped", 32'(bus.swapped), 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.ready), 32'd1);

    // ---- frame A into bank 1, dropped write and second loaded in PENDING
    fill_frame(8'hed);
    check("fill_ready", 32'(bus.ready), 32'd1);
    pulse_loaded();
    check("pend_ready",   32'(bus.ready),   32'd0);
    check("pend_swapped", 32'(bus.swapped), 32'd0);
    bus.loaded = 1'b1;
    write_px(0, 0, 24'hffffff);
    bus.loaded = 1'b0;
    tick();
    check("pend2_swapped", 32'(bus.swapped), 32'd0);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    check("swap_pulse", 32'(bus.swapped), 32'd1);
    check("swap_ready", 32'(bus.ready),   32'd0);
    tick();
    check("after_swap_pulse", 32'(bus.swapped), 32'd0);
    check("after_swap_ready", 32'(bus.ready),   32'd1);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    check("fill_fe_swapped", 32'(bus.swapped), 32'd0);
    tick();
    check("single_swap", 32'(bus.swapped), 32'd0);

    // ---- stream every pixel of frame A back
    bus.ren = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.rrow = RW'(r);
        bus.rcol = CW'(c);
        tick();
        check("frameA_rvalid", 32'(bus.rvalid), 32'd1);
        check("frameA_rdata",  32'(bus.rdata),  32'(px(r, 8'hed, c)));
      end
    end
    bus.ren = 1'b0;
    tick();
    check("idle_rvalid", 32'(bus.rvalid), 32'd0);
    check("idle_hold",   32'(bus.rdata),  32'(px(7, 8'hed, 31)));

    // ---- frame B into bank 0, continuous reads across SWAP
    fill_frame(8'hb0);
    pulse_loaded();
    bus.frame_end = 1'b1;
    bus.ren  = 1'b1;
    bus.rrow = RW'(1);
    bus.rcol = CW'(1);
    tick();
    bus.frame_end = 1'b0;
    check("xs_swapped", 32'(bus.swapped), 32'd1);
    check("xs_pend_rd", 32'(bus.rdata),   32'(px(1, 8'hed, 1)));
    bus.rrow = RW'(2);
    bus.rcol = CW'(2);
    tick();
    check("xs_swap_rd", 32'(bus.rdata), 32'(px(2, 8'hed, 2)));
    check("xs_ready",   32'(bus.ready), 32'd1);
    bus.rrow = RW'(3);
    bus.rcol = CW'(3);
    tick();
    bus.ren = 1'b0;
    check("xs_new_rd", 32'(bus.rdata), 32'(px(3, 8'hb0, 3)));

    // ---- loaded+frame_end together, write in the loaded cycle
    bus.loaded    = 1'b1;
    bus.frame_end = 1'b1;
    write_px(4, 4, px(4, 8'hc5, 4));
    bus.loaded    = 1'b0;
    bus.frame_end = 1'b0;
    check("lf_swapped", 32'(bus.swapped), 32'd0);
    check("lf_ready",   32'(bus.ready),   32'd0);
    tick();
    check("lf_wait_swapped", 32'(bus.swapped), 32'd0);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    check("lf_swap_pulse", 32'(bus.swapped), 32'd1);
    tick();
    read_px("lf_new_px",  4, 4, px(4, 8'hc5, 4));
    read_px("stale_px",   5, 5, px(5, 8'hed, 5));

    // ---- reset in PENDING aborts the swap
    write_px(6, 6, px(6, 8'hd6, 6));
    pulse_loaded();
    check("ab_pend_ready", 32'(bus.ready), 32'd0);
    bus.frame_end = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("ab_ready",   32'(bus.ready),   32'd1);
    check("ab_swapped", 32'(bus.swapped), 32'd0);
    check("ab_rdata",   32'(bus.rdata),   32'd0);
    tick();
    tick();
    check("ab_hold_swapped", 32'(bus.swapped), 32'd0);
    bus.frame_end = 1'b0;
    rst = 1'b1;
    tick();
    check("ab_rel_ready", 32'(bus.ready), 32'd1);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    check("ab_fe_swapped", 32'(bus.swapped), 32'd0);
    read_px("ab_front0_a", 4, 4, px(4, 8'hb0, 4));
    read_px("ab_front0_b", 6, 6, px(6, 8'hd6, 6));

    // ---- normal cycle after the aborted one
    write_px(7, 7, px(7, 8'he7, 7));
    pulse_loaded();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    check("re_swap_pulse", 32'(bus.swapped), 32'd1);
    tick();
    check("re_ready", 32'(bus.ready), 32'd1);
    read_px("re_new_px", 7, 7, px(7, 8'he7, 7));
    read_px("re_stale",  0, 1, px(0, 8'hed, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
